// File: rtl/ysyx_22050019_pkg.sv
// ysyx_22050019_pkg: shared widths and writeback request types for the regfile write scheduler
package ysyx_22050019_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam int NUM_REGS = 32;
  typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_t;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/ysyx_22050019_wb_arb.sv
// ysyx_22050019_wb_arb: 2-way writeback arbiter, fixed LSU priority or round-robin
// when YSYX_22050019_WB_RR_EN is defined
module ysyx_22050019_wb_arb
  import ysyx_22050019_pkg::*;
(
`ifdef YSYX_22050019_WB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt
);
`ifdef YSYX_22050019_WB_RR_EN
  wb_src_t last;
  always_ff @(posedge clk) begin
    if (rst) last <= WB_SRC_ALU;
    else if (alu_gnt | lsu_gnt) last <= lsu_gnt ? WB_SRC_LSU : WB_SRC_ALU;
  end
  always_comb begin
    lsu_gnt = lsu_valid & (!alu_valid | last == WB_SRC_ALU);
    alu_gnt = alu_valid & !lsu_gnt;
  end
`else
  always_comb begin
    lsu_gnt = lsu_valid;
    alu_gnt = alu_valid & !lsu_valid;
  end
`endif
endmodule

// File: rtl/ysyx_22050019_regs_sched.sv
// ysyx_22050019_regs_sched: register scoreboard, RAW/WAW issue stall and registered regfile write port
// arbitration mode selected by YSYX_22050019_WB_RR_EN (see ysyx_22050019_wb_arb)
module ysyx_22050019_regs_sched
  import ysyx_22050019_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_rs1_en,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic                  issue_rs2_en,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  lsu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_wb_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wb_data,
  output logic                  lsu_wb_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]   busy_vec
);
  wb_req_t alu_req, lsu_req, sel;
  logic gnt, stall, flush_seen;
  logic [NUM_REGS-1:0] set_mask, clr_mask, busy_nxt;
  ysyx_22050019_wb_arb u_arb (
`ifdef YSYX_22050019_WB_RR_EN
    .clk(clk),
    .rst(rst),
`endif
    .alu_valid(alu_wb_valid),
    .lsu_valid(lsu_wb_valid),
    .alu_gnt(alu_wb_ready),
    .lsu_gnt(lsu_wb_ready)
  );
  always_comb begin
    alu_req = {alu_wb_valid, alu_wb_addr, alu_wb_data};
    lsu_req = {lsu_wb_valid, lsu_wb_addr, lsu_wb_data};
    sel = lsu_wb_ready ? lsu_req : alu_req;
    gnt = (alu_wb_ready | lsu_wb_ready) & sel.valid;
    stall = (issue_rs1_en & busy_vec[issue_rs1]) | (issue_rs2_en & busy_vec[issue_rs2])
          | (issue_wen & busy_vec[issue_rd]);
    issue_ready = !stall & !flush & !rst;
    set_mask = (issue_valid & issue_ready & issue_wen) ? NUM_REGS'(1) << issue_rd : '0;
    clr_mask = gnt ? NUM_REGS'(1) << sel.addr : '0;
    // set is applied after clear so a same-cycle set on the same bit wins
    busy_nxt = flush ? '0 : ((busy_vec & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      rf_wen <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      flush_seen <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      rf_wen <= gnt & (sel.addr != '0);
      rf_waddr <= gnt ? sel.addr : rf_waddr;
      rf_wdata <= gnt ? sel.data : rf_wdata;
      flush_seen <= flush_seen | flush;
    end
  end
  // a writeback to an idle register only makes sense once a flush has dropped its busy bit
  always_ff @(posedge clk) begin
    if (!rst && gnt && sel.addr != '0 && !flush_seen) assert (busy_vec[sel.addr]);
  end
endmodule
